// File: rtl/ham_pkg.sv
// ----------------------------------------------------------------------------
// ham_pkg : shared widths and enums for the Hamming BIST controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ham_pkg;

  localparam int INFO_W = 12;
  localparam int CODE_W = 17;
  localparam int DIS_W  = 4;
  localparam int CNT_W  = 13;
  localparam int POS_W  = 5;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2,
    RSVD   = 2'd3
  } ham_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

endpackage

`default_nettype wire

// File: rtl/ham_bist_ctrl_if.sv
// ----------------------------------------------------------------------------
// ham_bist_ctrl_if : control, datapath and result signals of the BIST sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ham_bist_ctrl_if;
  import ham_pkg::*;

  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [INFO_W-1:0] start_word;
  logic [CNT_W-1:0]  num_words;
  logic [DIS_W-1:0]  ham_dis;
  logic [INFO_W-1:0] info_bits;
  logic [CODE_W-1:0] err_mask;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  fail_cnt;
  logic [DIS_W-1:0]  max_dis;
  logic [INFO_W-1:0] first_fail;
  logic              first_fail_vld;

  modport master (
    output start, abort, mode, start_word, num_words, ham_dis,
    input  info_bits, err_mask, busy, done, fail_cnt, max_dis,
           first_fail, first_fail_vld
  );

  modport slave (
    input  start, abort, mode, start_word, num_words, ham_dis,
    output info_bits, err_mask, busy, done, fail_cnt, max_dis,
           first_fail, first_fail_vld
  );

endinterface

`default_nettype wire

// File: rtl/ham_err_mask_gen.sv
// ----------------------------------------------------------------------------
// ham_err_mask_gen : error-injection mask for a bit position and error mode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ham_err_mask_gen
  import ham_pkg::*;
(
  input  logic [POS_W-1:0]  pos,
  input  ham_mode_t         mode,
  output logic [CODE_W-1:0] mask
);

  localparam logic [CODE_W-1:0] C_ONE = CODE_W'(1);

  logic [POS_W-1:0] w_pos_pair;

  // Second bit of a double error wraps from the top bit back to bit 0
  assign w_pos_pair = (pos == POS_W'(CODE_W - 1)) ? '0 : pos + POS_W'(1);

  always_comb begin
    mask = '0;
    case (mode)
      SINGLE:  mask = C_ONE << pos;
      DOUBLE:  mask = (C_ONE << pos) | (C_ONE << w_pos_pair);
      default: mask = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ham_bist_ctrl.sv
// ----------------------------------------------------------------------------
// ham_bist_ctrl : sweeps info words with injected errors, tallies ham_dis results
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ham_bist_ctrl
  import ham_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ham_bist_ctrl_if.slave bus
);

  bist_state_t       r_state;
  bist_state_t       w_state_nxt;
  ham_mode_t         r_mode;
  ham_mode_t         w_mode_sel;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [POS_W-1:0]  w_pos_sel;
  logic [INFO_W-1:0] r_info_bits;
  logic [INFO_W-1:0] r_first_fail;
  logic [CODE_W-1:0] r_err_mask;
  logic [CODE_W-1:0] w_mask;
  logic [DIS_W-1:0]  r_max_dis;
  logic              r_first_fail_vld;
  logic              w_accept;
  logic              w_sample;
  logic              w_last;

  // The mask generator serves both the first vector (from the start inputs)
  // and every following one (from the latched mode and advanced position).
  ham_err_mask_gen u_mask_gen (
    .pos  (w_pos_sel),
    .mode (w_mode_sel),
    .mask (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    w_pos_nxt   = (r_pos == POS_W'(CODE_W - 1)) ? '0 : r_pos + POS_W'(1);
    w_pos_sel   = w_pos_nxt;
    w_mode_sel  = r_mode;
    case (r_state)
      IDLE: begin
        w_pos_sel  = '0;
        w_mode_sel = ham_mode_t'(bus.mode);
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.num_words != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        w_sample = 1'b1;
        w_last   = (r_rem == CNT_W'(1)) || bus.abort;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode           <= NONE;
      r_rem            <= '0;
      r_pos            <= '0;
      r_info_bits      <= '0;
      r_err_mask       <= '0;
      r_fail_cnt       <= '0;
      r_max_dis        <= '0;
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fail_cnt       <= '0;
        r_max_dis        <= '0;
        r_first_fail     <= '0;
        r_first_fail_vld <= 1'b0;
        if (bus.num_words != '0) begin
          r_info_bits <= bus.start_word;
          r_err_mask  <= w_mask;
          r_rem       <= bus.num_words;
          r_pos       <= '0;
          r_mode      <= w_mode_sel;
        end
      end
      if (w_sample) begin
        if (bus.ham_dis != '0) begin
          r_fail_cnt <= r_fail_cnt + CNT_W'(1);
          if (!r_first_fail_vld) begin
            r_first_fail     <= r_info_bits;
            r_first_fail_vld <= 1'b1;
          end
        end
        if (bus.ham_dis > r_max_dis) begin
          r_max_dis <= bus.ham_dis;
        end
        if (w_last) begin
          r_err_mask <= '0;
        end else begin
          r_info_bits <= r_info_bits + INFO_W'(1);
          r_pos       <= w_pos_nxt;
          r_rem       <= r_rem - CNT_W'(1);
          r_err_mask  <= w_mask;
        end
      end
    end
  end

  assign bus.info_bits      = r_info_bits;
  assign bus.err_mask       = r_err_mask;
  assign bus.busy           = (r_state == RUN);
  assign bus.done           = (r_state == DONE);
  assign bus.fail_cnt       = r_fail_cnt;
  assign bus.max_dis        = r_max_dis;
  assign bus.first_fail     = r_first_fail;
  assign bus.first_fail_vld = r_first_fail_vld;

endmodule

`default_nettype wire

// File: tb/tb_ham_bist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ham_bist_ctrl : directed bench for ham_bist_ctrl with a Hamming(17,12) model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ham_bist_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   stub_sel;
  logic [11:0] stub_word;
  logic [3:0]  stub_val;

  ham_bist_ctrl_if bif ();

  ham_bist_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data bits sit at the non-power-of-two positions 3,5,6,7,9..15,17
  function automatic logic [16:0] ham_enc(input logic [11:0] d);
    logic [16:0] c;
    logic        par;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 17; p++) begin
        if (((p >> i) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ c[p-1];
      end
      c[(1 << i) - 1] = par;
    end
    return c;
  endfunction

  function automatic logic [11:0] ham_dec(input logic [16:0] cw);
    logic [16:0] c;
    logic [11:0] d;
    int          syn;
    int          j;
    c   = cw;
    syn = 0;
    for (int p = 1; p <= 17; p++) if (c[p-1]) syn = syn ^ p;
    if (syn >= 1 && syn <= 17) c[syn-1] = ~c[syn-1];
    d = '0;
    j = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [3:0] real_dis(input logic [11:0] i, input logic [16:0] m);
    return 4'($countones(ham_dec(ham_enc(i) ^ m) ^ i));
  endfunction

  always_comb begin
    bif.ham_dis = '0;
    case (stub_sel)
      0: bif.ham_dis = real_dis(bif.info_bits, bif.err_mask);
      1: if (bif.info_bits == stub_word) bif.ham_dis = stub_val;
      2: bif.ham_dis = 4'($countones(bif.err_mask));
      3: bif.ham_dis = stub_val;
      default: bif.ham_dis = '0;
    endcase
  end

  task automatic do_start(input logic [1:0] m, input logic [11:0] sw, input logic [12:0] n);
    @(negedge clk);
    bif.start      = 1'b1;
    bif.mode       = m;
    bif.start_word = sw;
    bif.num_words  = n;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int busy_cycles);
    seen        = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bif.busy) busy_cycles++;
      if (bif.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bif.info_bits, bif.err_mask, bif.busy, bif.done, bif.fail_cnt, bif.max_dis,
         bif.first_fail, bif.first_fail_vld} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got info=%h mask=%h busy=%b done=%b fail=%0d max=%0d ff=%h vld=%b, want all 0",
               bif.info_bits, bif.err_mask, bif.busy, bif.done, bif.fail_cnt, bif.max_dis,
               bif.first_fail, bif.first_fail_vld);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_sweep;
    bit seen;
    int bc;
    stub_sel = 0;
    do_start(2'd0, 12'h000, 13'd4096);
    wait_done(5000, seen, bc);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL clean_done: got no done within 5000 cycles, want done");
    end
    n_cmp++;
    if (bc !== 4096) begin
      n_bad++;
      $display("FAIL clean_busy_cycles: got %0d, want 4096", bc);
    end
    n_cmp++;
    if ({bif.fail_cnt, bif.max_dis, bif.first_fail_vld} !== '0) begin
      n_bad++;
      $display("FAIL clean_results: got fail=%0d max=%0d vld=%b, want 0 0 0",
               bif.fail_cnt, bif.max_dis, bif.first_fail_vld);
    end
    n_cmp++;
    if (bif.info_bits !== 12'hFFF) begin
      n_bad++;
      $display("FAIL clean_last_info: got %h, want fff", bif.info_bits);
    end
    @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_done_pulse: got done=%b busy=%b, want 0 0", bif.done, bif.busy);
    end
  endtask

  task automatic test_single_bit;
    logic [16:0] em;
    logic [11:0] ei;
    stub_sel = 0;
    do_start(2'd1, 12'h123, 13'd17);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      em = 17'd1 << k;
      ei = 12'h123 + 12'(k);
      n_cmp++;
      if (bif.err_mask !== em || bif.info_bits !== ei || bif.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_vec%0d: got mask=%h info=%h busy=%b, want mask=%h info=%h busy=1",
                 k, bif.err_mask, bif.info_bits, bif.busy, em, ei);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b1 || bif.err_mask !== '0 || bif.fail_cnt !== '0) begin
      n_bad++;
      $display("FAIL single_done: got done=%b mask=%h fail=%0d, want 1 00000 0",
               bif.done, bif.err_mask, bif.fail_cnt);
    end
  endtask

  task automatic test_stub_compare;
    bit seen;
    int bc;
    stub_sel  = 1;
    stub_word = 12'h015;
    stub_val  = 4'd3;
    do_start(2'd0, 12'h010, 13'd8);
    wait_done(20, seen, bc);
    n_cmp++;
    if (!seen || bc !== 8) begin
      n_bad++;
      $display("FAIL stub_timing: got seen=%b busy=%0d, want 1 8", seen, bc);
    end
    n_cmp++;
    if (bif.fail_cnt !== 13'd1 || bif.max_dis !== 4'd3 || bif.first_fail !== 12'h015
        || bif.first_fail_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL stub_results: got fail=%0d max=%0d ff=%h vld=%b, want 1 3 015 1",
               bif.fail_cnt, bif.max_dis, bif.first_fail, bif.first_fail_vld);
    end
  endtask

  task automatic test_wrap;
    logic [16:0] em;
    logic [11:0] ei;
    int pos;
    int np;
    stub_sel = 2;
    do_start(2'd2, 12'hFFE, 13'd18);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      pos = k % 17;
      np  = (pos + 1) % 17;
      em  = (17'd1 << pos) | (17'd1 << np);
      ei  = 12'hFFE + 12'(k);
      n_cmp++;
      if (bif.err_mask !== em || bif.info_bits !== ei) begin
        n_bad++;
        $display("FAIL wrap_vec%0d: got mask=%h info=%h, want mask=%h info=%h",
                 k, bif.err_mask, bif.info_bits, em, ei);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b1 || bif.err_mask !== '0 || bif.info_bits !== 12'h00F) begin
      n_bad++;
      $display("FAIL wrap_done: got done=%b mask=%h info=%h, want 1 00000 00f",
               bif.done, bif.err_mask, bif.info_bits);
    end
    n_cmp++;
    if (bif.fail_cnt !== 13'd18 || bif.max_dis !== 4'd2 || bif.first_fail !== 12'hFFE) begin
      n_bad++;
      $display("FAIL wrap_results: got fail=%0d max=%0d ff=%h, want 18 2 ffe",
               bif.fail_cnt, bif.max_dis, bif.first_fail);
    end
  endtask

  task automatic test_abort;
    logic [11:0] ei;
    stub_sel = 3;
    stub_val = 4'd1;
    do_start(2'd0, 12'h200, 13'd100);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ei = 12'h200 + 12'(c - 1);
      n_cmp++;
      if (bif.busy !== 1'b1 || bif.info_bits !== ei) begin
        n_bad++;
        $display("FAIL abort_run%0d: got busy=%b info=%h, want 1 %h", c, bif.busy, bif.info_bits, ei);
      end
      if (c == 3) begin
        bif.start      = 1'b1;
        bif.start_word = 12'hABC;
        bif.num_words  = 13'd5;
      end
      if (c == 4) bif.start = 1'b0;
      if (c == 10) bif.abort = 1'b1;
    end
    @(negedge clk);
    bif.abort = 1'b0;
    n_cmp++;
    if (bif.done !== 1'b1 || bif.busy !== 1'b0 || bif.info_bits !== 12'h209) begin
      n_bad++;
      $display("FAIL abort_done: got done=%b busy=%b info=%h, want 1 0 209",
               bif.done, bif.busy, bif.info_bits);
    end
    n_cmp++;
    if (bif.fail_cnt !== 13'd10 || bif.max_dis !== 4'd1 || bif.first_fail !== 12'h200) begin
      n_bad++;
      $display("FAIL abort_results: got fail=%0d max=%0d ff=%h, want 10 1 200",
               bif.fail_cnt, bif.max_dis, bif.first_fail);
    end
  endtask

  task automatic test_zero_length;
    do_start(2'd1, 12'h055, 13'd0);
    @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b1 || bif.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done: got done=%b busy=%b, want 1 0", bif.done, bif.busy);
    end
    n_cmp++;
    if ({bif.fail_cnt, bif.max_dis, bif.first_fail, bif.first_fail_vld} !== '0) begin
      n_bad++;
      $display("FAIL zero_results: got fail=%0d max=%0d ff=%h vld=%b, want all 0",
               bif.fail_cnt, bif.max_dis, bif.first_fail, bif.first_fail_vld);
    end
  endtask

  task automatic test_reset_mid_run;
    int bad_cycles;
    stub_sel = 3;
    stub_val = 4'd2;
    do_start(2'd1, 12'h300, 13'd50);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bif.info_bits, bif.err_mask, bif.busy, bif.done, bif.fail_cnt, bif.max_dis,
         bif.first_fail, bif.first_fail_vld} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got info=%h mask=%h busy=%b done=%b fail=%0d max=%0d ff=%h vld=%b, want all 0",
               bif.info_bits, bif.err_mask, bif.busy, bif.done, bif.fail_cnt, bif.max_dis,
               bif.first_fail, bif.first_fail_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    bad_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bif.done !== 1'b0 || bif.busy !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d cycles with done/busy, want 0", bad_cycles);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    stub_sel       = 0;
    stub_word      = '0;
    stub_val       = '0;
    rst            = 1'b1;
    bif.start      = 1'b0;
    bif.abort      = 1'b0;
    bif.mode       = 2'd0;
    bif.start_word = '0;
    bif.num_words  = '0;
    test_reset();
    test_clean_sweep();
    test_single_bit();
    test_stub_compare();
    test_wrap();
    test_abort();
    test_zero_length();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ham_bist_ctrl.md
# ham_bist_ctrl

Self-test sequencer for the Hamming encode/decode/compare datapath. It sweeps a programmable range of 12-bit info words through the encoder, injects 0, 1 or 2 bit errors into the 17-bit codeword before the decoder, samples the resulting Hamming distance each cycle, and accumulates pass/fail statistics. It sits beside the combinational datapath: it drives `info_bits` and an error mask, and reads back `ham_dis`.

## Interface
- `INFO_W`, 12, info word width
- `CODE_W`, 17, codeword width (error-mask width)
- `DIS_W`, 4, Hamming-distance width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin run; accepted only in IDLE
- `abort`  in  1  terminate run; effective in RUN only
- `mode`  in  2  0 = no error, 1 = single-bit, 2 = double-bit, 3 = reserved (behaves as 0); latched at start
- `start_word`  in  12  first info word; latched at start
- `num_words`  in  13  vector count, 0..4096; latched at start
- `ham_dis`  in  4  distance from the compare stage for the currently driven vector
- `info_bits`  out  12  registered info word to the encoder
- `err_mask`  out  17  registered mask, XORed onto the codeword ahead of the decoder
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at end of run, including after abort
- `fail_cnt`  out  13  number of vectors with `ham_dis != 0`
- `max_dis`  out  4  largest `ham_dis` sampled in the run
- `first_fail`  out  12  info word of the first failing vector
- `first_fail_vld`  out  1  `first_fail` holds valid data

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start` with `num_words != 0`: go to RUN. Load `info_bits <= start_word`, `err_mask <= mask(pos = 0)`, `rem <= num_words`, `pos <= 0`. Clear `fail_cnt`, `max_dis`, `first_fail`, `first_fail_vld`.
  - On `start` with `num_words == 0`: clear the results and go directly to DONE.
- RUN, every edge:
  - Sample `ham_dis` for the current vector. On a nonzero sample, increment `fail_cnt`; if `first_fail_vld == 0`, set `first_fail <= info_bits` and `first_fail_vld <= 1`. Update `max_dis` with the larger of itself and `ham_dis`.
  - If `rem == 1` or `abort`: go to DONE and set `err_mask <= 0`. `info_bits` holds.
  - Otherwise: `info_bits <= info_bits + 1` mod 4096 (0xFFF wraps to 0x000), `pos <= (pos == 16) ? 0 : pos + 1`, `rem <= rem - 1`, load the next mask.
- Mask generation:
  - mode 1: bit `pos`.
  - mode 2: bits `pos` and `(pos + 1) mod 17`, so pos 16 gives bits 16 and 0.
  - mode 0 and mode 3: zero.
- DONE lasts one cycle with `done = 1`, then returns to IDLE. Results hold until the next accepted start.
- `start` during RUN or DONE is ignored.
- `abort` and `start` are ignored outside RUN and IDLE respectively.
- When `abort` is asserted in the last vector's cycle, the vector is still sampled; DONE follows as normal.
- `fail_cnt` cannot overflow, because at most 4096 vectors are sampled.

## Timing
- Reset value of every output and internal register is 0; state is IDLE.
- Start accepted at edge E0. Vector k is driven in cycle k+1 after E0 and sampled at edge E(k+1).
- `busy` is high for exactly N cycles. `done` is high in cycle N+1.
- With `num_words == 0`, `done` is high in the cycle after E0 and `busy` never rises.
- Throughput is one vector per cycle. The datapath must settle within one clock period.
- Assertion of `rst` mid-run takes effect immediately: state returns to IDLE, all outputs clear, and no `done` is generated.

## Structure
- Package `ham_pkg` holds:
  - `INFO_W`, `CODE_W`, `DIS_W`;
  - `ham_mode_t` (NONE, SINGLE, DOUBLE, RSVD);
  - `bist_state_t` (IDLE, RUN, DONE).
- One sub-module, `ham_err_mask_gen`: purely combinational, mapping `pos` (5 bits) and `mode` to the 17-bit mask.
- The controller holds the FSM, counters and result registers. The bench instantiates the existing encoder, decoder and compare stages around it, with an XOR on the codeword.

## Test plan
- Clean sweep: mode 0, `start_word` 0x000, `num_words` 4096, real datapath -> `busy` high 4096 cycles, `done` pulse, `fail_cnt` 0, `max_dis` 0, `first_fail_vld` 0.
- Single-bit errors: mode 1, `start_word` 0x123, `num_words` 17 -> `err_mask` walks 0x00001 through 0x10000, `fail_cnt` 0.
- Stubbed compare: `ham_dis` forced to 3 on vector 5 only, mode 0, `start_word` 0x010, `num_words` 8 -> `fail_cnt` 1, `max_dis` 3, `first_fail` 0x015.
- Wrap-around: mode 2, `start_word` 0xFFE, `num_words` 18 -> `info_bits` runs 0xFFE, 0xFFF, 0x000, …; the mask at pos 16 is 0x10001; the mask returns to 0 in DONE.
- Abort: mode 0, `num_words` 100, `abort` on the 10th RUN cycle -> 10 vectors sampled, `done` on the next cycle; a `start` during RUN is ignored.
- Zero length and reset: `num_words` 0 -> `done` one cycle after start, results 0. Assert `rst` mid-run -> all outputs 0 asynchronously, no `done`.
